// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_pkg : shared types and helpers for the Wishbone RR arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_MASTERS = 8;

  // Index reported on gnt_id while nobody owns the bus.
  localparam logic [2:0] NO_OWNER = 3'd0;

  function automatic logic [2:0] gnt2id(input logic [MAX_MASTERS-1:0] onehot);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (onehot[i]) id = id | 3'(i);
    end
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_if : Wishbone B4 classic/registered-feedback signal bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ADR;
  logic [DATA_WIDTH-1:0]   DAT_W;
  logic [DATA_WIDTH-1:0]   DAT_R;
  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic [DATA_WIDTH/8-1:0] SEL;
  logic [2:0]              CTI;
  logic [1:0]              BTE;
  logic                    ACK;
  logic                    ERR;

  modport master (
    output ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE,
    output DAT_R, ACK, ERR
  );
endinterface
`default_nettype wire

// File: rtl/wb_arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_rr_pick : combinational round-robin picker, one-hot grant     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_arb_rr_pick #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  input  logic          last_valid,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pool;

  // Prefer requesters strictly above the last winner; otherwise wrap to the
  // lowest index. With no history the mask is empty, so index 0 leads.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = last_valid && (IW'(i) > last_gnt);
    end
    req_hi = req & hi_mask;
    pool   = (|req_hi) ? req_hi : req;
    gnt    = pool & (-pool);
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter_rr : N-master to one-slave Wishbone round-robin arbiter;  |
// | optional stall watchdog enabled by WB_ARB_TIMEOUT_EN.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter  int N_MASTERS      = 3,
  parameter  int WB_ADDR_WIDTH  = 32,
  parameter  int WB_DATA_WIDTH  = 32,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int ID_W           = $clog2(N_MASTERS),
  localparam int SEL_W          = WB_DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_ADR,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_DAT_W,
  input  logic [N_MASTERS-1:0]               m_CYC,
  input  logic [N_MASTERS-1:0]               m_STB,
  input  logic [N_MASTERS-1:0]               m_WE,
  input  logic [N_MASTERS*SEL_W-1:0]         m_SEL,
  input  logic [N_MASTERS*3-1:0]             m_CTI,
  input  logic [N_MASTERS*2-1:0]             m_BTE,
  output logic [N_MASTERS-1:0]               m_ACK,
  output logic [N_MASTERS-1:0]               m_ERR,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_DAT_R,
  wb_if.master                               s,
  output logic [ID_W-1:0]                    gnt_id,
  output logic                               gnt_valid
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_gnt_q, last_gnt_d;
  logic            last_valid_q, last_valid_d;
  logic            gnt_valid_q, gnt_valid_d;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [ID_W-1:0]      pick_id;
  logic                 own_cyc;
  logic                 own_stb;
  logic                 wd_expire;

  logic [WB_ADDR_WIDTH-1:0] adr_a   [N_MASTERS];
  logic [WB_DATA_WIDTH-1:0] dat_w_a [N_MASTERS];
  logic [SEL_W-1:0]         sel_a   [N_MASTERS];
  logic [2:0]               cti_a   [N_MASTERS];
  logic [1:0]               bte_a   [N_MASTERS];

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign adr_a[g]   = m_ADR[g*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    assign dat_w_a[g] = m_DAT_W[g*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign sel_a[g]   = m_SEL[g*SEL_W +: SEL_W];
    assign cti_a[g]   = m_CTI[g*3 +: 3];
    assign bte_a[g]   = m_BTE[g*2 +: 2];
  end

  wb_arb_rr_pick #(.N(N_MASTERS)) u_pick (
    .req        (m_CYC),
    .last_gnt   (last_gnt_q),
    .last_valid (last_valid_q),
    .gnt        (pick_gnt)
  );

  assign pick_id = ID_W'(gnt2id(8'(pick_gnt)));
  assign own_cyc = m_CYC[owner_q];
  assign own_stb = m_STB[owner_q];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d      = '0;
    wd_expire = 1'b0;
    if (state_q == GRANT && own_cyc && own_stb && !s.ACK && !s.ERR) begin
      wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      wd_d      = (wd_q == WD_W'(TIMEOUT_CYCLES)) ? wd_q : wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_gnt_d   = last_gnt_q;
    last_valid_d = last_valid_q;
    gnt_valid_d  = gnt_valid_q;
    unique case (state_q)
      IDLE: begin
        if (|m_CYC) begin
          state_d      = GRANT;
          owner_d      = pick_id;
          last_gnt_d   = pick_id;
          last_valid_d = 1'b1;
          gnt_valid_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_d     = IDLE;
          owner_d     = ID_W'(NO_OWNER);
          gnt_valid_d = 1'b0;
        end else if (wd_expire) begin
          state_d = ABORT;
        end
      end
      ABORT:   state_d = GRANT;
      default: begin
        state_d     = IDLE;
        owner_d     = ID_W'(NO_OWNER);
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= ID_W'(NO_OWNER);
      last_gnt_q   <= '0;
      last_valid_q <= 1'b0;
      gnt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_gnt_q   <= last_gnt_d;
      last_valid_q <= last_valid_d;
      gnt_valid_q  <= gnt_valid_d;
    end
  end

  // Request path: owner's signals forwarded; CYC/STB suppressed during an
  // abort and as soon as reset is seen, so the slave never sees a stale cycle.
  always_comb begin
    s.ADR   = '0;
    s.DAT_W = '0;
    s.WE    = 1'b0;
    s.SEL   = '0;
    s.CTI   = '0;
    s.BTE   = '0;
    s.CYC   = 1'b0;
    s.STB   = 1'b0;
    if (state_q != IDLE) begin
      s.ADR   = adr_a[owner_q];
      s.DAT_W = dat_w_a[owner_q];
      s.WE    = m_WE[owner_q];
      s.SEL   = sel_a[owner_q];
      s.CTI   = cti_a[owner_q];
      s.BTE   = bte_a[owner_q];
    end
    if (state_q == GRANT) begin
      s.CYC = own_cyc;
      s.STB = own_stb;
    end
    if (rst) begin
      s.CYC = 1'b0;
      s.STB = 1'b0;
    end
  end

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_resp
    logic is_own;
    assign is_own   = (owner_q == ID_W'(g));
    assign m_ACK[g] = (state_q == GRANT) && is_own && s.ACK;
    assign m_ERR[g] = is_own && (((state_q == GRANT) && s.ERR) || (state_q == ABORT));
    assign m_DAT_R[g*WB_DATA_WIDTH +: WB_DATA_WIDTH] =
      ((state_q == GRANT) && is_own) ? s.DAT_R : '0;
  end

  assign gnt_id    = owner_q;
  assign gnt_valid = gnt_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_arbiter_rr : randomized masters/slave against a transaction    |
// | level ownership model. Rev 1.0                                       |
// +----------------------------------------------------------------------+
module tb_wb_arbiter_rr;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_ADR;
  logic [N*DW-1:0] m_DAT_W;
  logic [N-1:0]    m_CYC, m_STB, m_WE;
  logic [N*SW-1:0] m_SEL;
  logic [N*3-1:0]  m_CTI;
  logic [N*2-1:0]  m_BTE;
  logic [N-1:0]    m_ACK, m_ERR;
  logic [N*DW-1:0] m_DAT_R;
  logic [IW-1:0]   gnt_id;
  logic            gnt_valid;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

  wb_arbiter_rr #(
    .N_MASTERS      (N),
    .WB_ADDR_WIDTH  (AW),
    .WB_DATA_WIDTH  (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_ADR     (m_ADR),
    .m_DAT_W   (m_DAT_W),
    .m_CYC     (m_CYC),
    .m_STB     (m_STB),
    .m_WE      (m_WE),
    .m_SEL     (m_SEL),
    .m_CTI     (m_CTI),
    .m_BTE     (m_BTE),
    .m_ACK     (m_ACK),
    .m_ERR     (m_ERR),
    .m_DAT_R   (m_DAT_R),
    .s         (sif),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Master behaviour: each active master runs a burst of `beats` accesses.
  bit          act  [N];
  bit          rest [N];
  int          beats[N];
  logic [AW-1:0] adr [N];
  logic [DW-1:0] dat [N];
  logic          we  [N];
  logic [SW-1:0] sel [N];
  logic [2:0]    cti [N];
  bit            mute;

  // Ownership model: owner index (-1 = nobody), last winner (-1 = none).
  int mo, ml, mstall;
  bit mab;

  function automatic void new_beat(input int i);
    adr[i] = $urandom;
    dat[i] = $urandom;
    we[i]  = 1'($urandom_range(0, 1));
    sel[i] = SW'($urandom);
    cti[i] = (beats[i] > 1) ? 3'b010 : 3'b111;
  endfunction

  function automatic void start_master(input int i, input int nb);
    act[i]   = 1'b1;
    rest[i]  = 1'b0;
    beats[i] = nb;
    new_beat(i);
  endfunction

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      if (!act[i]) begin
        if (rest[i]) rest[i] = 1'b0;
        else if ($urandom_range(0, 5) == 0) start_master(i, $urandom_range(1, 4));
      end
      m_CYC[i]            = act[i];
      m_STB[i]            = act[i] && (mute || $urandom_range(0, 7) != 0);
      m_ADR[i*AW +: AW]   = adr[i];
      m_DAT_W[i*DW +: DW] = dat[i];
      m_WE[i]             = we[i];
      m_SEL[i*SW +: SW]   = sel[i];
      m_CTI[i*3 +: 3]     = cti[i];
      m_BTE[i*2 +: 2]     = 2'b00;
    end
  endtask

  task automatic one_cycle(input bit do_rst);
    bit           own;
    bit           exp_cyc;
    logic [N-1:0] exp_ack, exp_err;
    logic [DW-1:0] exp_dat;
    bit           found;
    int           c;

    @(negedge clk);
    rst = do_rst;
    drive_masters();
    #1;
    sif.ACK   = 1'b0;
    sif.ERR   = 1'b0;
    sif.DAT_R = $urandom;
    if (sif.CYC && sif.STB) begin
      if (!mute) begin
        c = $urandom_range(0, 15);
        sif.ACK = (c < 5);
        sif.ERR = (c == 5);
      end
    end else if ($urandom_range(0, 15) == 0) begin
      sif.ACK = 1'b1;
    end
    #1;

    if (do_rst) begin
      check("rst_s_cyc", 64'(sif.CYC), 64'd0);
      check("rst_s_stb", 64'(sif.STB), 64'd0);
      mo = -1; ml = -1; mab = 1'b0; mstall = 0;
      for (int i = 0; i < N; i++) begin
        act[i]  = 1'b0;
        rest[i] = 1'b0;
      end
      return;
    end

    own     = (mo >= 0);
    exp_cyc = own && !mab && m_CYC[mo];
    check("gnt_valid", 64'(gnt_valid), 64'(own));
    check("gnt_id", 64'(gnt_id), own ? 64'(mo) : 64'd0);
    check("s_cyc", 64'(sif.CYC), 64'(exp_cyc));
    check("s_stb", 64'(sif.STB), 64'(exp_cyc && m_STB[mo]));
    if (exp_cyc) begin
      check("s_adr", 64'(sif.ADR), 64'(adr[mo]));
      check("s_dat_w", 64'(sif.DAT_W), 64'(dat[mo]));
      check("s_ctl", 64'({sif.WE, sif.SEL, sif.CTI, sif.BTE}),
            64'({we[mo], sel[mo], cti[mo], 2'b00}));
    end

    exp_ack = '0;
    exp_err = '0;
    if (own && !mab) begin
      exp_ack[mo] = sif.ACK;
      exp_err[mo] = sif.ERR;
    end
    if (own && mab) exp_err[mo] = 1'b1;
    check("m_ack", 64'(m_ACK), 64'(exp_ack));
    check("m_err", 64'(m_ERR), 64'(exp_err));
    for (int i = 0; i < N; i++) begin
      exp_dat = (own && !mab && i == mo) ? sif.DAT_R : '0;
      check("m_dat_r", 64'(m_DAT_R[i*DW +: DW]), 64'(exp_dat));
    end

    // Advance the ownership model to the next cycle.
    if (!own) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (ml + k + N) % N;
        if (!found && m_CYC[c]) begin
          found = 1'b1;
          mo = c; ml = c; mstall = 0;
        end
      end
    end else if (mab) begin
      mab = 1'b0;
      mstall = 0;
    end else if (!m_CYC[mo]) begin
      mo = -1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    else begin
      if (m_STB[mo] && !sif.ACK && !sif.ERR) begin
        mstall++;
        if (mstall == TO) begin
          mab = 1'b1;
          mstall = 0;
        end
      end else begin
        mstall = 0;
      end
    end
`endif

    for (int i = 0; i < N; i++) begin
      if (act[i] && exp_err[i]) begin
        act[i]  = 1'b0;
        rest[i] = 1'b1;
      end else if (act[i] && exp_ack[i] && m_STB[i]) begin
        beats[i]--;
        if (beats[i] == 0) begin
          act[i]  = 1'b0;
          rest[i] = 1'b1;
        end else begin
          new_beat(i);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    mute      = 1'b0;
    m_ADR     = '0; m_DAT_W = '0; m_CYC = '0; m_STB = '0; m_WE = '0;
    m_SEL     = '0; m_CTI = '0; m_BTE = '0;
    sif.ACK   = 1'b0;
    sif.ERR   = 1'b0;
    sif.DAT_R = '0;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; rest[i] = 1'b0; beats[i] = 0;
      adr[i] = '0; dat[i] = '0; we[i] = 1'b0; sel[i] = '0; cti[i] = '0;
    end
    mo = -1; ml = -1; mab = 1'b0; mstall = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt_valid", 64'(gnt_valid), 64'd0);
    check("reset_gnt_id", 64'(gnt_id), 64'd0);
    check("reset_s_bus", 64'({sif.CYC, sif.STB, sif.WE, sif.SEL, sif.CTI, sif.BTE}), 64'd0);
    check("reset_s_adr", 64'(sif.ADR), 64'd0);
    check("reset_s_dat_w", 64'(sif.DAT_W), 64'd0);
    check("reset_m_resp", 64'({m_ACK, m_ERR}), 64'd0);
    check("reset_m_dat_r", 64'(m_DAT_R), 64'd0);

    // All masters request together with one beat each to open the run.
    for (int i = 0; i < N; i++) start_master(i, 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      mute = (cyc >= 800 && cyc < 850) || (cyc >= 2000 && cyc < 2040);
      one_cycle(cyc == 1500 || cyc == 2600 || cyc == 0);
      if (cyc == 0) begin
        for (int i = 0; i < N; i++) start_master(i, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_rr.md
# wb_arbiter_rr

Shares a single Wishbone slave port between N Wishbone masters using registered round-robin arbitration with bus ownership held for the full CYC. It sits in front of any single-ported target (memory, peripheral bridge) or in front of one slave port of a Wishbone interconnect, replacing per-slave ad-hoc arbitration. An optional watchdog terminates stalled accesses with ERR.

## Interface
- N_MASTERS, 3, number of requesting masters, 2..8
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width, multiple of 8
- TIMEOUT_CYCLES, 256, stall limit in cycles, 2..65535; used only with the watchdog
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- m_ADR / m_DAT_W  in  N_MASTERS×WB_ADDR_WIDTH / N_MASTERS×WB_DATA_WIDTH  master i at slice i
- m_CYC, m_STB, m_WE  in  N_MASTERS  per-master controls
- m_SEL  in  N_MASTERS×WB_DATA_WIDTH/8
- m_CTI / m_BTE  in  N_MASTERS×3 / N_MASTERS×2
- m_ACK, m_ERR  out  N_MASTERS  per-master responses
- m_DAT_R  out  N_MASTERS×WB_DATA_WIDTH
- s  wb_if.master  slave port (ADR, DAT_W, DAT_R, CYC, STB, WE, SEL, CTI, BTE, ACK, ERR)
- gnt_id  out  $clog2(N_MASTERS)  current owner; 0 when idle
- gnt_valid  out  1  an owner holds the bus

## Operation
- State IDLE: request vector req[i] = m_CYC[i]. If any set, pick winner by round-robin: first set bit strictly above last_gnt, wrapping; if last_gnt none (after reset), lowest index. Register owner, last_gnt; go GRANT.
- State GRANT: slave outputs = owner's inputs; owner's m_ACK/m_ERR/m_DAT_R = slave's. Non-owners: ACK=ERR=0, DAT_R=0. When owner's m_CYC is 0: clear owner, go IDLE.
- State ABORT (watchdog only): slave CYC=STB=0; owner m_ERR=1, m_ACK=0 for exactly one cycle; next state GRANT with watchdog cleared.
- Owner is never preempted; bursts (CTI≠0) and read-modify-write sequences stay atomic while CYC held.
- Slave ACK/ERR arriving while no owner is dropped.
- Reset mid-transaction: all state to IDLE next edge; slave CYC/STB drop immediately with reset asserted-registered state.

## Timing
- Reset values: all slave-port outputs 0, all m_ACK/m_ERR 0, m_DAT_R 0, gnt_valid 0, gnt_id 0, last_gnt none.
- Grant latency: CYC rises at edge k → owner registered at edge k+1; slave sees CYC/STB from cycle k+1.
- Release: owner drops CYC in cycle j → IDLE after edge j+1; next grant at edge j+2 (one dead cycle between owners).
- Response path combinational: slave ACK/ERR/DAT_R to owner in same cycle, zero added latency.
- Simultaneous requests all resolved by round-robin; a master requesting in the release cycle competes at the next IDLE evaluation.
- Watchdog counter: increments each GRANT cycle with owner STB=1 and slave ACK=ERR=0; clears on ACK/ERR or STB=0; reaching TIMEOUT_CYCLES-1 → ABORT at next edge. Counter width $clog2(TIMEOUT_CYCLES+1), saturates never wraps.

## Configuration
- WB_ARB_TIMEOUT_EN defined: watchdog counter and ABORT state present.
- Undefined: no counter, no ABORT state; a stalled slave holds the bus indefinitely; TIMEOUT_CYCLES ignored.

## Structure
- Package wb_arb_pkg: state enum (IDLE, GRANT, ABORT), gnt2id one-hot-to-index function, NO_OWNER constant.
- Sub-module wb_arb_rr_pick: combinational round-robin picker (req, last_gnt → one-hot gnt), reusable by future interconnect variants.
- Top holds FSM, owner register, slave mux, response demux, watchdog.

## Test plan
- Single master: m1 CYC/STB write ADR=0x100, slave ACKs 2 cycles later → slave CYC from cycle after request, m1 ACK same cycle as s.ACK, gnt_id=1.
- Contention: m0,m1,m2 all raise CYC at cycle 0, each one single-beat access → grant order 0,1,2 with one idle cycle between owners.
- Fairness wrap: after m2 served, m0 and m2 request → m0 granted; repeat → m2 then m0 alternate.
- Lock: m0 holds CYC for 4-beat incrementing burst CTI=010 while m1 requests → m1 not granted until edge after m0 CYC drops.
- Watchdog (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never ACKs → after 8 stalled cycles slave CYC=0 one cycle, m0 ERR=1 one cycle, m0 retains grant.
- Reset mid-burst: rst high during m1 beat 2 → next cycle all outputs at reset values, gnt_valid=0; after release m0 request granted first.
